// File: rtl/alu_issue_if.sv
// Issue-side bus of alu_issue: instruction handshake, ALU control/result, retirement and debug read.
interface alu_issue_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [2:0]  alu_func3;
  logic        alu_subsra;
  logic [31:0] alu_result;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        done_illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output in_valid, in_instr, alu_result, dbg_addr,
    input  in_ready, alu_operand1, alu_operand2, alu_func3, alu_subsra,
           done, done_rd, done_data, done_illegal, dbg_data
  );

  modport slave (
    input  in_valid, in_instr, alu_result, dbg_addr,
    output in_ready, alu_operand1, alu_operand2, alu_func3, alu_subsra,
           done, done_rd, done_data, done_illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue/decode front-end with 32x32 register file driving an external ALU.
// Define ALU_ISSUE_OPIMM_EN to decode OP-IMM; otherwise opcode 0010011 retires illegal.
module alu_issue (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   bus
);
  // state | meaning
  // IDLE  | ready for an instruction
  // DECODE| read operands, decode, register ALU controls
  // EXEC  | capture ALU result
  // WB    | write back, pulse done
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  logic [1:0]  state;
  logic [31:0] instr_q;
  logic [31:0] result_q;
  logic        legal_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [2:0]  func3_q;
  logic        subsra_q;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign func3   = instr_q[14:12];
  assign rs1     = instr_q[19:15];
  assign rs2     = instr_q[24:20];
  assign funct7  = instr_q[31:25];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  logic        dec_legal;
  logic        dec_subsra;
  logic [31:0] dec_op2;

  always_comb begin
    dec_legal  = 1'b0;
    dec_subsra = 1'b0;
    dec_op2    = rs2_val;
    if (opcode == 7'b0110011) begin
      if (funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
      end else if (funct7 == 7'b0100000) begin
        dec_legal  = (func3 == 3'b000) || (func3 == 3'b101);
        dec_subsra = 1'b1;
      end
    end
`ifdef ALU_ISSUE_OPIMM_EN
    else if (opcode == 7'b0010011) begin
      dec_op2 = {{20{instr_q[31]}}, instr_q[31:20]};
      // Shifts carry shamt in rs2's field; funct7 selects logical vs arithmetic.
      if (func3 == 3'b001) begin
        dec_legal = (funct7 == 7'b0000000);
        dec_op2   = {27'd0, instr_q[24:20]};
      end else if (func3 == 3'b101) begin
        dec_legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        dec_subsra = instr_q[30];
        dec_op2    = {27'd0, instr_q[24:20]};
      end else begin
        dec_legal = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      legal_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      func3_q  <= '0;
      subsra_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            instr_q <= bus.in_instr;
            state   <= DECODE;
          end
        end
        DECODE: begin
          op1_q    <= rs1_val;
          op2_q    <= dec_op2;
          func3_q  <= func3;
          subsra_q <= dec_subsra;
          legal_q  <= dec_legal;
          state    <= EXEC;
        end
        EXEC: begin
          result_q <= bus.alu_result;
          state    <= WB;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == WB && legal_q && rd != 5'd0) begin
      rf[rd] <= result_q;
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_func3    = func3_q;
  assign bus.alu_subsra   = subsra_q;
  assign bus.done         = (state == WB);
  assign bus.done_rd      = (state == WB) ? rd : 5'd0;
  assign bus.done_data    = (state == WB && legal_q) ? result_q : 32'd0;
  assign bus.done_illegal = (state == WB) && !legal_q;
  assign bus.dbg_data     = (bus.dbg_addr == 5'd0) ? 32'd0 : rf[bus.dbg_addr];
endmodule
